// File: rtl/rca_multiword_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rca_multiword_sequencer
// Description : Adds two NIBBLES x 4-bit operands through an external
//               combinational 4-bit ripple-carry adder, one nibble per cycle,
//               LSB nibble first, and reports the wide result with a
//               valid/ready handshake.
// Ports       : clk, rst_n         - clock, synchronous active-low reset
//               in_valid/in_ready  - request handshake (op_a, op_b, op_cin)
//               add_a/add_b/add_cin- drive to the external 4-bit adder
//               add_sum/add_carry  - same-cycle response of that adder
//               out_valid/out_ready- result handshake (result, cout, ovf)
// Revision    : 1.0 - initial release
// ============================================================================
module rca_multiword_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);

    localparam logic [IDXW-1:0] c_last = IDXW'(NIBBLES - 1);
    localparam logic [IDXW-1:0] c_one  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_c;
    // Partial sums of all but the top nibble. Slices arrive LSB first and are
    // shifted in from the top, so after NIBBLES-1 slices nibble 0 sits at bit 0.
    logic [W-5:0]    r_res;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;

    logic            w_last;
    logic [W-1:0]    w_shift;

    assign w_last  = (r_idx == c_last);
    assign w_shift = {add_sum, r_res};

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

    // Next state and handshake / adder drive
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        add_a        = 4'd0;
        add_b        = 4'd0;
        add_cin      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = r_a[{r_idx, 2'b00} +: 4];
                add_b   = r_b[{r_idx, 2'b00} +: 4];
                add_cin = r_c;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_res    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= op_a;
                        r_b   <= op_b;
                        r_c   <= op_cin;
                        r_idx <= '0;
                    end
                end
                ST_RUN: begin
                    r_res <= w_shift[W-1:4];
                    r_c   <= add_carry;
                    if (w_last) begin
                        r_idx    <= '0;
                        r_result <= w_shift;
                        r_cout   <= add_carry;
                        // Signed overflow: like-signed operands give an
                        // opposite-signed result.
                        r_ovf    <= (r_a[W-1] == r_b[W-1]) &&
                                    (add_sum[3] != r_a[W-1]);
                    end else begin
                        r_idx <= r_idx + c_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rca_multiword_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rca_multiword_sequencer
// Description : Self-checking bench for rca_multiword_sequencer (NIBBLES=4)
//               with a behavioural 4-bit adder and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_multiword_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];

    rca_multiword_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    // External combinational 4-bit ripple-carry adder
    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per completed output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got result %h with no expected entry", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", 32'(result), 32'(e.r));
                check("sb_cout",   32'(cout),   32'(e.c));
                check("sb_ovf",    32'(ovf),    32'(e.o));
            end
        end
    end

    // Issue one request and follow it until out_valid rises; returns the
    // per-slice add_a and add_cin sequences (first slice in the MSBs).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] er, input logic ec, input logic eo,
                          output logic [15:0] sa, output logic [3:0] sc);
        int n;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) check("accept_timeout", 32'(in_ready), 32'd1);
        exp_q.push_back('{r: er, c: ec, o: eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        sa = '0;
        sc = '0;
        for (int k = 0; k < 4; k++) begin
            sa = {sa[11:0], add_a};
            sc = {sc[2:0], add_cin};
            check("run_busy", {30'd0, in_ready, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input logic [15:0] er);
        @(posedge clk); #1;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready), 32'd1);
        check("hold_idle",   32'(result), 32'(er));
    endtask

    initial begin
        logic [15:0] sa;
        logic [3:0]  sc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_result",   32'(result), 32'd0);
        check("rst_cout",     32'(cout), 32'd0);
        check("rst_ovf",      32'(ovf), 32'd0);
        check("rst_out_valid",32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_add",      {23'd0, add_a, add_b, add_cin}, 32'd0);

        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, sa, sc);
        check("seq_add_a", 32'(sa), 32'h4321);
        drain(16'h2345);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, sa, sc);
        check("seq_add_cin", 32'(sc), 32'h7);
        drain(16'h0000);

        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, sa, sc);
        drain(16'h8000);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, sa, sc);
        drain(16'h0000);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, sa, sc);
        check("seq_cin0", 32'(sc), 32'h8);
        drain(16'h0001);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, sa, sc);
        drain(16'hFFFF);

        // Backpressure in DONE with a pending new request
        out_ready = 1'b0;
        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, sa, sc);
        op_a     = 16'hAAAA;
        op_b     = 16'h5555;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_result",   32'(result), 32'h2345);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        run_op(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, sa, sc);
        check("bp_seq_add_a", 32'(sa), 32'hAAAA);
        drain(16'hFFFF);

        // Reset after two RUN slices abandons the operation
        op_a     = 16'h1234;
        op_b     = 16'h1111;
        op_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_run_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst_in_ready",  32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_result",    32'(result), 32'd0);
        check("mrst_add",       {23'd0, add_a, add_b, add_cin}, 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, sa, sc);
        drain(16'h0002);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
